// File: rtl/vga_framebuffer_scanout.sv
// vga_framebuffer_scanout: raster timing generator that fetches framebuffer pixels and drives aligned VGA outputs
module vga_framebuffer_scanout #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 19,
  parameter int PIX_W    = 8
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] fb_address,
  output logic              fb_rd_en,
  input  logic [PIX_W-1:0]  fb_data,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank_n,
  output logic [PIX_W-1:0]  vga_pixel,
  output logic              frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  logic [DW-1:0]     div_cnt;
  logic [HW-1:0]     h;
  logic [VW-1:0]     v;
  logic [ADDR_W-1:0] addr;
  logic pix_en, active, h_end, v_end;
  logic pix_d, rd_d, hs_d, vs_d, first_d;
  // reset gates the strobe so no read is issued while reset is held
  always_comb begin
    pix_en = ~reset && div_cnt == '0;
    active = h < H_VIS && v < V_VIS;
    h_end = h == H_LAST;
    v_end = v == V_LAST;
    fb_rd_en = pix_en && active;
    fb_address = addr;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
      h <= '0;
      v <= '0;
      addr <= '0;
      pix_d <= 1'b0;
      rd_d <= 1'b0;
      hs_d <= 1'b1;
      vs_d <= 1'b1;
      first_d <= 1'b0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_pixel <= '0;
      frame_start <= 1'b0;
    end else begin
      div_cnt <= div_cnt == DIV_LAST ? '0 : div_cnt + DW'(1);
      if (pix_en) begin
        h <= h_end ? '0 : h + HW'(1);
        if (h_end) v <= v_end ? '0 : v + VW'(1);
        addr <= h_end && v_end ? '0 : addr + ADDR_W'(fb_rd_en);
      end
      pix_d <= pix_en;
      rd_d <= fb_rd_en;
      hs_d <= !(h >= HS_BEG && h <= HS_LAST);
      vs_d <= !(v >= VS_BEG && v <= VS_LAST);
      first_d <= h == '0 && v == '0;
      // fb_data is only trusted when a read was issued on the previous clock
      if (pix_d) begin
        vga_pixel <= rd_d ? fb_data : '0;
        vga_blank_n <= rd_d;
        vga_hs <= hs_d;
        vga_vs <= vs_d;
      end
      frame_start <= pix_d && first_d;
    end
  end
endmodule
